// File: rtl/e_n_chk_pkg.sv
// Shared types and helpers for the e_n_chk_acc column accumulator.
// Holds the frame FSM state enum and the beat-counter width function.
package e_n_chk_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter must be able to hold the value ROWS itself, not just ROWS-1.
    function automatic int cnt_width(input int rows);
        return (rows < 1) ? 1 : $clog2(rows + 1);
    endfunction

endpackage

// File: rtl/e_n_chk_acc_lane.sv
// One column lane of e_n_chk_acc: a Z_BITS accumulator with add-enable
// and synchronous clear; sums wrap modulo 2^Z_BITS.
module chk_acc_lane #(
    parameter int A_BITS = 8,
    parameter int Z_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [A_BITS-1:0] a,
    output logic [Z_BITS-1:0] z
);

    logic [Z_BITS-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_q <= '0;
        end else if (add_en) begin
            sum_q <= sum_q + Z_BITS'(a);
        end
    end

    assign z = sum_q;

endmodule

// File: rtl/e_n_chk_acc.sv
// Frame accumulator: sums ROWS accepted beats per lane, then presents the sums
// until acknowledged. Optional checksum compare under macro E_N_CHK_ACC_CMP_EN.
module e_n_chk_acc
    import e_n_chk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ROWS   = 4,
    parameter int A_BITS = 8,
    parameter int Z_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*A_BITS-1:0] a,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*Z_BITS-1:0] z,
    input  logic [NUM_CH*Z_BITS-1:0] ref_chk,
    output logic [NUM_CH-1:0]        err,
    output logic                     err_any,
    output state_t                   dbg_state
);

    localparam int CNT_W = cnt_width(ROWS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROWS - 1);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // the result transfers on a rising edge where out_valid && out_ready.
    // in_ready and out_valid are registered and depend only on the FSM state.
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic accept;
    logic release_frame;
    logic lane_clr;
    logic lane_add;

    assign accept        = in_valid && in_ready_q;
    assign release_frame = (state_q == HOLD) && out_ready;
    assign lane_clr      = clear || release_frame;
    assign lane_add      = accept && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= ACC;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dbg_state = state_q;

    logic [Z_BITS-1:0] lane_z [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        chk_acc_lane #(
            .A_BITS(A_BITS),
            .Z_BITS(Z_BITS)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (lane_clr),
            .add_en(lane_add),
            .a     (a[k*A_BITS +: A_BITS]),
            .z     (lane_z[k])
        );
        assign z[k*Z_BITS +: Z_BITS] = lane_z[k];
    end

`ifdef E_N_CHK_ACC_CMP_EN
    // Compare is gated by out_valid, so ref_chk only matters while in HOLD.
    always_comb begin
        err = '0;
        if (out_valid_q) begin
            for (int k = 0; k < NUM_CH; k++) begin
                err[k] = (lane_z[k] != ref_chk[k*Z_BITS +: Z_BITS]);
            end
        end
    end
    assign err_any = |err;
`else
    logic unused_ref_chk;
    assign unused_ref_chk = ^ref_chk;
    assign err     = '0;
    assign err_any = 1'b0;
`endif

endmodule
